// File: rtl/aemb2_pkg.sv
// Shared definitions for the AEMB2 data-memory stage: access size codes,
// controller state encoding and the default data-bus address width.
package aemb2_pkg;

    localparam int DWB_DEFAULT = 32;

    localparam logic [1:0] SIZ_BYTE = 2'd0;
    localparam logic [1:0] SIZ_HALF = 2'd1;
    localparam logic [1:0] SIZ_WORD = 2'd2;
    localparam logic [1:0] SIZ_FSL  = 2'd3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/aemb2_dmem_ctrl_if.sv
// Wishbone classic data-bus bundle between the data-memory controller
// (master) and the memory/interconnect (slave).
// Handshake: the master raises stb with we/adr/sel/dat stable and holds
// them until the slave answers with ack; ack is sampled only while the
// master's strobe is up, and one ack completes exactly one transfer.
interface aemb2_dmem_ctrl_if #(
    parameter int DWB = aemb2_pkg::DWB_DEFAULT
);
    logic           dwb_cyc_o;
    logic           dwb_stb_o;
    logic           dwb_we_o;
    logic [DWB-3:0] dwb_adr_o;
    logic [3:0]     dwb_sel_o;
    logic [31:0]    dwb_dat_o;
    logic           dwb_ack_i;
    logic [31:0]    dwb_dat_i;

    modport master (
        output dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o,
        input  dwb_ack_i, dwb_dat_i
    );

    modport slave (
        input  dwb_cyc_o, dwb_stb_o, dwb_we_o, dwb_adr_o, dwb_sel_o, dwb_dat_o,
        output dwb_ack_i, dwb_dat_i
    );
endinterface

// File: rtl/aemb2_dmem_lane.sv
// Big-endian byte-lane helper: lane selects, store-data replication and
// load-data extraction with zero extension. Purely combinational so the
// FSL path can reuse it unchanged.
module aemb2_dmem_lane
    import aemb2_pkg::*;
(
    input  logic [1:0]  siz,
    input  logic [1:0]  off,
    input  logic [31:0] wdat,
    input  logic [31:0] rdat,
    output logic [3:0]  sel,
    output logic [31:0] wrep,
    output logic [31:0] rext
);

    // Decode size and byte offset into lanes; offset 0 is the MSB lane.
    always_comb begin
        sel  = 4'h0;
        wrep = wdat;
        rext = 32'h0;
        case (siz)
            SIZ_BYTE: begin
                sel  = 4'b1000 >> off;
                wrep = {4{wdat[7:0]}};
                case (off)
                    2'd0:    rext = {24'h0, rdat[31:24]};
                    2'd1:    rext = {24'h0, rdat[23:16]};
                    2'd2:    rext = {24'h0, rdat[15:8]};
                    default: rext = {24'h0, rdat[7:0]};
                endcase
            end
            SIZ_HALF: begin
                sel  = off[1] ? 4'h3 : 4'hC;
                wrep = {2{wdat[15:0]}};
                rext = off[1] ? {16'h0, rdat[15:0]} : {16'h0, rdat[31:16]};
            end
            SIZ_WORD: begin
                sel  = 4'hF;
                wrep = wdat;
                rext = rdat;
            end
            default: begin
                sel  = 4'h0;
                wrep = wdat;
                rext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/aemb2_dmem_ctrl.sv
// AEMB2 data-memory controller: runs one Wishbone classic cycle per
// load/store from execute, stalls the pipeline until ack, and returns
// aligned zero-extended load data as a one-cycle valid pulse.
// Optional bus timeout: define AEMB2_DMEM_TMO_EN.
module aemb2_dmem_ctrl
    import aemb2_pkg::*;
#(
    parameter int DWB = DWB_DEFAULT,
    parameter int TMO = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [1:0]        siz_i,
    input  logic [DWB-1:0]    adr_i,
    input  logic [31:0]       dat_i,
    input  logic              be_i,
    aemb2_dmem_ctrl_if.master dwb,
    output logic              stall_o,
    output logic              ld_vld_o,
    output logic [31:0]       ld_dat_o,
    output logic              err_o,
    output state_t            dbgState
);

    state_t      state, stateNext;
    logic        stbNext;
    logic        accept, done, tmoHit;
    logic [1:0]  accSiz, accOff;
    logic        accWe;
    logic [3:0]  reqSel;
    logic [31:0] reqDat, ldExt;
    logic [31:0] unusedReqExt, unusedLdRep;
    logic [3:0]  unusedLdSel;

    // Request-side lanes come from the live execute inputs.
    aemb2_dmem_lane uReqLane (
        .siz  (siz_i),
        .off  (adr_i[1:0]),
        .wdat (dat_i),
        .rdat (32'h0),
        .sel  (reqSel),
        .wrep (reqDat),
        .rext (unusedReqExt)
    );

    // Load extraction uses the size/offset captured when the cycle started.
    aemb2_dmem_lane uLdLane (
        .siz  (accSiz),
        .off  (accOff),
        .wdat (32'h0),
        .rdat (dwb.dwb_dat_i),
        .sel  (unusedLdSel),
        .wrep (unusedLdRep),
        .rext (ldExt)
    );

`ifdef AEMB2_DMEM_TMO_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmoCnt;
    logic          errQ;

    assign tmoHit = (state == BUSY) & ~dwb.dwb_ack_i & (tmoCnt == CW'(TMO - 1));
    assign err_o  = errQ;

    // Count unacknowledged strobe cycles; a simultaneous ack beats the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmoCnt <= '0;
            errQ   <= 1'b0;
        end else begin
            errQ <= tmoHit;
            if (accept)
                tmoCnt <= '0;
            else if ((state == BUSY) && !dwb.dwb_ack_i)
                tmoCnt <= tmoCnt + CW'(1);
        end
    end
`else
    logic unusedTmo;
    assign unusedTmo = (TMO != 0);
    assign tmoHit    = 1'b0;
    assign err_o     = 1'b0;
`endif

    assign stall_o  = (state == BUSY) & ~dwb.dwb_ack_i;
    assign dbgState = state;

    // Next-state and strobe decode; FSL-sized requests never touch the bus.
    always_comb begin
        accept    = (state == IDLE) & req_i & (siz_i != SIZ_FSL);
        done      = (state == BUSY) & (dwb.dwb_ack_i | tmoHit);
        stateNext = state;
        stbNext   = dwb.dwb_stb_o;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = BUSY;
                    stbNext   = 1'b1;
                end
            end
            BUSY: begin
                if (done) begin
                    stateNext = IDLE;
                    stbNext   = 1'b0;
                end
            end
            default: begin
                stateNext = IDLE;
                stbNext   = 1'b0;
            end
        endcase
    end

    // State, registered bus outputs and load return; reset drops cyc/stb at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            dwb.dwb_cyc_o <= 1'b0;
            dwb.dwb_stb_o <= 1'b0;
            dwb.dwb_we_o  <= 1'b0;
            dwb.dwb_adr_o <= '0;
            dwb.dwb_sel_o <= 4'h0;
            dwb.dwb_dat_o <= 32'h0;
            accSiz        <= SIZ_BYTE;
            accOff        <= 2'd0;
            accWe         <= 1'b0;
            ld_vld_o      <= 1'b0;
            ld_dat_o      <= 32'h0;
        end else begin
            state         <= stateNext;
            dwb.dwb_stb_o <= stbNext;
            dwb.dwb_cyc_o <= stbNext | be_i;
            ld_vld_o      <= done & ~accWe;
            if (accept) begin
                dwb.dwb_we_o  <= we_i;
                dwb.dwb_adr_o <= adr_i[DWB-1:2];
                dwb.dwb_sel_o <= reqSel;
                dwb.dwb_dat_o <= reqDat;
                accSiz        <= siz_i;
                accOff        <= adr_i[1:0];
                accWe         <= we_i;
            end
            if (done && !accWe)
                ld_dat_o <= dwb.dwb_ack_i ? ldExt : 32'h0;
        end
    end

endmodule

// File: tb/tb_aemb2_dmem_ctrl.sv
// Directed bench for aemb2_dmem_ctrl: a vector table of single accesses
// plus hand-written sequences for bus lock, reset mid-cycle, FSL no-ops,
// stray acks and (when AEMB2_DMEM_TMO_EN is defined) the bus timeout.
module tb_aemb2_dmem_ctrl;
    import aemb2_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_i, we_i, be_i;
    logic [1:0]  siz_i;
    logic [31:0] adr_i, dat_i;
    logic        stall_o, ld_vld_o, err_o;
    logic [31:0] ld_dat_o;
    state_t      dbgState;

    int checks   = 0;
    int failures = 0;
    logic [31:0] lastLd = 32'h0;

    aemb2_dmem_ctrl_if #(.DWB(32)) dwb ();

    aemb2_dmem_ctrl #(.DWB(32), .TMO(4)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .we_i     (we_i),
        .siz_i    (siz_i),
        .adr_i    (adr_i),
        .dat_i    (dat_i),
        .be_i     (be_i),
        .dwb      (dwb),
        .stall_o  (stall_o),
        .ld_vld_o (ld_vld_o),
        .ld_dat_o (ld_dat_o),
        .err_o    (err_o),
        .dbgState (dbgState)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [1:0]  siz;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [31:0] rdat;
        int          waits;
        logic [3:0]  expSel;
        logic [31:0] expDat;
        logic [31:0] expLd;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after an edge with the controller idle; returns #1 after
    // the completion edge so a following call exercises back-to-back issue.
    task automatic access(input vec_t v, input logic expCyc);
        req_i = 1'b1; we_i = v.we; siz_i = v.siz; adr_i = v.adr; dat_i = v.dat;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        chk("stb_start", {31'h0, dwb.dwb_stb_o}, 32'h1);
        chk("cyc_start", {31'h0, dwb.dwb_cyc_o}, 32'h1);
        chk("we", {31'h0, dwb.dwb_we_o}, {31'h0, v.we});
        chk("adr", {2'b00, dwb.dwb_adr_o}, {2'b00, v.adr[31:2]});
        chk("sel", {28'h0, dwb.dwb_sel_o}, {28'h0, v.expSel});
        chk("dat_o", dwb.dwb_dat_o, v.expDat);
        chk("no_vld_start", {31'h0, ld_vld_o}, 32'h0);
        for (int w = 0; w < v.waits; w++) begin
            chk("stall_wait", {31'h0, stall_o}, 32'h1);
            @(posedge clk_i); #1;
            chk("stb_wait", {31'h0, dwb.dwb_stb_o}, 32'h1);
        end
        dwb.dwb_ack_i = 1'b1;
        dwb.dwb_dat_i = v.rdat;
        #1;
        chk("stall_ack", {31'h0, stall_o}, 32'h0);
        @(posedge clk_i); #1;
        dwb.dwb_ack_i = 1'b0;
        dwb.dwb_dat_i = 32'h0;
        chk("stb_end", {31'h0, dwb.dwb_stb_o}, 32'h0);
        chk("cyc_end", {31'h0, dwb.dwb_cyc_o}, {31'h0, expCyc});
        chk("ld_vld", {31'h0, ld_vld_o}, {31'h0, ~v.we});
        chk("err_end", {31'h0, err_o}, 32'h0);
        if (!v.we) lastLd = v.expLd;
        chk("ld_dat", ld_dat_o, lastLd);
    endtask

    initial begin
        vec_t v;
        //          we    siz       adr           dat           rdat          w  sel   expDat        expLd
        vecs[0]  = '{1'b0, SIZ_BYTE, 32'h0000_1001, 32'h0,        32'hAABB_CCDD, 0, 4'h4, 32'h0,        32'h0000_00BB};
        vecs[1]  = '{1'b1, SIZ_HALF, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        3, 4'h3, 32'hABCD_ABCD, 32'h0};
        vecs[2]  = '{1'b0, SIZ_BYTE, 32'h0000_0000, 32'h0,        32'hAABB_CCDD, 1, 4'h8, 32'h0,        32'h0000_00AA};
        vecs[3]  = '{1'b0, SIZ_BYTE, 32'h0000_0002, 32'h0,        32'h1122_3344, 0, 4'h2, 32'h0,        32'h0000_0033};
        vecs[4]  = '{1'b0, SIZ_BYTE, 32'h0000_0003, 32'h0,        32'h1122_3344, 0, 4'h1, 32'h0,        32'h0000_0044};
        vecs[5]  = '{1'b0, SIZ_HALF, 32'h0000_0010, 32'h0,        32'h1122_3344, 0, 4'hC, 32'h0,        32'h0000_1122};
        vecs[6]  = '{1'b0, SIZ_HALF, 32'h0000_0013, 32'h0,        32'h1122_3344, 2, 4'h3, 32'h0,        32'h0000_3344};
        vecs[7]  = '{1'b1, SIZ_BYTE, 32'h0000_0005, 32'h0000_00A5, 32'h0,        0, 4'h4, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b1, SIZ_WORD, 32'h0000_0008, 32'hDEAD_BEEF, 32'h0,        1, 4'hF, 32'hDEAD_BEEF, 32'h0};
        vecs[9]  = '{1'b0, SIZ_WORD, 32'h0000_000C, 32'h0,        32'hCAFE_F00D, 0, 4'hF, 32'h0,        32'hCAFE_F00D};
        vecs[10] = '{1'b1, SIZ_BYTE, 32'h0000_0007, 32'hFFFF_FF5A, 32'h0,        0, 4'h1, 32'h5A5A_5A5A, 32'h0};

        rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; siz_i = SIZ_BYTE; be_i = 1'b0;
        adr_i = 32'h0; dat_i = 32'h0; dwb.dwb_ack_i = 1'b0; dwb.dwb_dat_i = 32'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_cyc", {31'h0, dwb.dwb_cyc_o}, 32'h0);
        chk("rst_stb", {31'h0, dwb.dwb_stb_o}, 32'h0);
        chk("rst_sel", {28'h0, dwb.dwb_sel_o}, 32'h0);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_vld", {31'h0, ld_vld_o}, 32'h0);
        chk("rst_lddat", ld_dat_o, 32'h0);
        chk("rst_err", {31'h0, err_o}, 32'h0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Table: consecutive calls issue back-to-back (request on return to IDLE).
        for (int i = 0; i < 11; i++) access(vecs[i], 1'b0);
        @(posedge clk_i); #1;
        chk("vld_clear", {31'h0, ld_vld_o}, 32'h0);
        chk("idle_cyc", {31'h0, dwb.dwb_cyc_o}, 32'h0);

        // Bus lock: cyc stays up around a word load, stb only during the access.
        be_i = 1'b1;
        @(posedge clk_i); #1;
        chk("lock_cyc_pre", {31'h0, dwb.dwb_cyc_o}, 32'h1);
        chk("lock_stb_pre", {31'h0, dwb.dwb_stb_o}, 32'h0);
        v = '{1'b0, SIZ_WORD, 32'h0000_0100, 32'h0, 32'h8765_4321, 0, 4'hF, 32'h0, 32'h8765_4321};
        access(v, 1'b1);
        @(posedge clk_i); #1;
        chk("lock_cyc_post", {31'h0, dwb.dwb_cyc_o}, 32'h1);
        chk("lock_stb_post", {31'h0, dwb.dwb_stb_o}, 32'h0);
        be_i = 1'b0;
        @(posedge clk_i); #1;
        chk("unlock_cyc", {31'h0, dwb.dwb_cyc_o}, 32'h0);

        // Reset in the middle of a strobe drops cyc/stb without a clock edge.
        req_i = 1'b1; we_i = 1'b0; siz_i = SIZ_WORD; adr_i = 32'h0000_0200;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        chk("mid_stb", {31'h0, dwb.dwb_stb_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("arst_cyc", {31'h0, dwb.dwb_cyc_o}, 32'h0);
        chk("arst_stb", {31'h0, dwb.dwb_stb_o}, 32'h0);
        chk("arst_stall", {31'h0, stall_o}, 32'h0);
        chk("arst_lddat", ld_dat_o, 32'h0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        lastLd = 32'h0;
        @(posedge clk_i); #1;
        chk("post_rst_idle", {31'h0, dbgState}, 32'h0);
        v = '{1'b0, SIZ_HALF, 32'h0000_0302, 32'h0, 32'h0BAD_F00D, 1, 4'h3, 32'h0, 32'h0000_F00D};
        access(v, 1'b0);

        // FSL-sized request and a stray ack while idle: nothing happens.
        req_i = 1'b1; we_i = 1'b0; siz_i = SIZ_FSL; adr_i = 32'h0000_0400;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i); #1;
            chk("fsl_cyc", {31'h0, dwb.dwb_cyc_o}, 32'h0);
            chk("fsl_stb", {31'h0, dwb.dwb_stb_o}, 32'h0);
            chk("fsl_stall", {31'h0, stall_o}, 32'h0);
            chk("fsl_vld", {31'h0, ld_vld_o}, 32'h0);
        end
        req_i = 1'b0;
        dwb.dwb_ack_i = 1'b1; dwb.dwb_dat_i = 32'hFFFF_FFFF;
        @(posedge clk_i); #1;
        dwb.dwb_ack_i = 1'b0;
        @(posedge clk_i); #1;
        chk("stray_vld", {31'h0, ld_vld_o}, 32'h0);
        chk("stray_lddat", ld_dat_o, lastLd);
        chk("stray_stb", {31'h0, dwb.dwb_stb_o}, 32'h0);

`ifdef AEMB2_DMEM_TMO_EN
        // Timeout with TMO=4: four strobe cycles, then abort with zero data.
        req_i = 1'b1; we_i = 1'b0; siz_i = SIZ_WORD; adr_i = 32'h0000_0500;
        @(posedge clk_i); #1;
        req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("tmo_stb", {31'h0, dwb.dwb_stb_o}, 32'h1);
            chk("tmo_err_low", {31'h0, err_o}, 32'h0);
            @(posedge clk_i); #1;
        end
        chk("tmo_stb_drop", {31'h0, dwb.dwb_stb_o}, 32'h0);
        chk("tmo_err", {31'h0, err_o}, 32'h1);
        chk("tmo_vld", {31'h0, ld_vld_o}, 32'h1);
        chk("tmo_lddat", ld_dat_o, 32'h0);
        lastLd = 32'h0;
        @(posedge clk_i); #1;
        chk("tmo_err_pulse", {31'h0, err_o}, 32'h0);
        // Ack in the fourth strobe cycle completes normally.
        v = '{1'b0, SIZ_WORD, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 3, 4'hF, 32'h0, 32'h1357_9BDF};
        access(v, 1'b0);
        @(posedge clk_i); #1;
        chk("tmo_ack_err", {31'h0, err_o}, 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aemb2_dmem_ctrl.md
Name: aemb2_dmem_ctrl

Overview:
- Data-memory stage directly downstream of the integer ASLU.
- Consumes the effective address, access size and store data computed in execute, and runs one Wishbone classic data cycle per load/store.
- Aligns and zero-extends load data for writeback, and raises a stall so the pipeline holds until the bus acknowledges.
- Big-endian byte lanes, consistent with the rest of the core.

Parameters:
- DWB, 32, data bus address width (byte address bits DWB-1:0).
- TMO, 255, bus-timeout limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  execute-stage memory request, sampled when idle.
- we_i  in  1  1 = store, 0 = load.
- siz_i  in  2  0 byte, 1 half, 2 word, 3 no-op (FSL).
- adr_i  in  DWB  effective byte address from the adder.
- dat_i  in  32  store operand (RD value), right-justified.
- be_i  in  1  MSR bus-lock enable.
- dwb_ack_i  in  1  Wishbone acknowledge.
- dwb_dat_i  in  32  Wishbone read data.
- dwb_cyc_o  out  1  Wishbone cycle.
- dwb_stb_o  out  1  Wishbone strobe.
- dwb_we_o  out  1  Wishbone write enable.
- dwb_adr_o  out  DWB-2  word address.
- dwb_sel_o  out  4  byte lane selects.
- dwb_dat_o  out  32  lane-replicated write data.
- stall_o  out  1  hold pipeline (ena low).
- ld_vld_o  out  1  one-cycle pulse: load data valid.
- ld_dat_o  out  32  aligned, zero-extended load data.
- err_o  out  1  one-cycle pulse: bus timeout.

Behaviour:
- Reset (async, rst_ni low):
  - all outputs 0; state IDLE; timeout counter 0.
  - an in-flight cycle is abandoned immediately: cyc and stb drop asynchronously.
- States: IDLE, BUSY.
- IDLE:
  - req_i=1 and siz_i!=3: go to BUSY next edge, registering dwb_stb_o=1, dwb_we_o=we_i, dwb_adr_o=adr_i[DWB-1:2], dwb_sel_o and dwb_dat_o.
  - siz_i=3: no bus cycle, no pulse, stay IDLE.
- Byte-lane select, big-endian, from adr_i[1:0]:
  - byte: offset 0→8, 1→4, 2→2, 3→1.
  - half: adr_i[1]=0→C, 1→3.
  - word: F.
  - Misalignment is not checked; low address bits are ignored beyond lane selection.
- Store data:
  - byte: {4{dat_i[7:0]}}.
  - half: {2{dat_i[15:0]}}.
  - word: dat_i.
- BUSY:
  - stb held with all bus outputs stable until dwb_ack_i=1.
  - On ack: next edge stb=0, state IDLE.
  - If the access was a load, ld_vld_o=1 for exactly one cycle, with ld_dat_o = selected lane(s) shifted to bit 0, upper bits zero.
  - ld_dat_o holds its value until the next load completes.
- dwb_cyc_o = stb | be_i, registered. be_i=1 keeps cyc asserted while idle (bus lock).
- stall_o is combinational: (state==BUSY) & ~dwb_ack_i.
- Minimum latency: req at cycle N, stb at N+1, ack at N+1 gives ld_vld at N+2. Stall is 0 when ack arrives in the first strobe cycle.
- req_i while BUSY is ignored; the pipeline is stalled, so this is an upstream error.
- dwb_ack_i while IDLE is ignored.
- Back-to-back: a new req_i may be accepted in the same cycle the FSM returns to IDLE (one idle bus cycle between accesses).

Optional Feature:
- Macro: AEMB2_DMEM_TMO_EN.
- Defined:
  - an 8-bit (clog2(TMO+1)) counter clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TMO, the cycle aborts: next edge stb=0, IDLE, err_o pulses one cycle.
  - A load abort also pulses ld_vld_o with ld_dat_o=32'h0.
  - Ack in the same cycle as the limit wins (normal completion, no err_o).
- Undefined: no counter; BUSY waits indefinitely; err_o tied 0.

Decomposition:
- Shared package aemb2_pkg: size encodings (SIZ_BYTE/HALF/WORD/FSL), state encoding, DWB default.
- Sub-module aemb2_dmem_lane:
  - purely combinational.
  - does sel generation, store replication and load extraction.
  - reusable by the FSL path.

Test Plan:
- Byte load, adr=0x1001, dwb_dat_i=0xAABBCCDD, ack on first stb cycle → sel=4, adr=0x400, ld_dat_o=0x000000BB, ld_vld 1 cycle, stall never high.
- Half store, adr=0x2002, dat_i=0x1234ABCD, ack after 3 wait cycles → sel=3, dat_o=0xABCDABCD, we=1, stall high exactly 3 cycles, no ld_vld.
- Word load with be_i=1, ack immediate → cyc stays 1 before and after, stb only in the access cycle, ld_dat_o=dwb_dat_i.
- rst_ni low mid-BUSY → cyc/stb 0 immediately; after release, IDLE and a new request completes normally.
- siz_i=3 request → no cyc/stb, no stall, no pulses.
- With AEMB2_DMEM_TMO_EN, TMO=4, no ack → stb high 4 cycles then low, err_o 1 cycle, load returns 0x0; ack on cycle 4 → normal completion, err_o 0.
